// File: rtl/pcs_am_insert.sv
// pcs_am_insert -- multi-lane PCS transmit alignment-marker inserter.
//
// Sits between per-lane 64b/66b encode+scramble and the PMA gearbox. Every
// GAP_N payload cycles one output cycle carries a per-lane alignment marker
// (all lanes at once) and the upstream is stalled through ready_o.
//
// Optional feature macro: PCS_AM_BIP_EN
//   defined   -> per-lane BIP8 accumulators fill the BIP3/BIP7 marker bytes
//   undefined -> BIP3 = 0x00, BIP7 = 0xFF in every marker
//
// Ports
//   clk      clock
//   reset    synchronous, active-high reset
//   head_i   [LANE_N*HEAD_W] per-lane sync header (bit 0 sent first)
//   data_i   [LANE_N*DATA_W] per-lane scrambled payload (bits [7:0] = byte 0)
//   ready_o  input consumed this cycle (combinational from the counter)
//   head_o   [LANE_N*HEAD_W] registered output header
//   data_o   [LANE_N*DATA_W] registered output payload
//   am_v_o   current output is an alignment marker

// Per-lane datapath: output block register plus optional BIP8 accumulator.
module pcs_am_lane #(
  parameter int          DATA_W = 64,
  parameter int          HEAD_W = 2,
  parameter logic [23:0] AM     = 24'h477690   // {M2,M1,M0}
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              mark,
  input  logic [HEAD_W-1:0] src_head,
  input  logic [DATA_W-1:0] src_data,
  output logic [HEAD_W-1:0] blk_head,
  output logic [DATA_W-1:0] blk_data
);
  localparam logic [HEAD_W-1:0] AM_HEAD = HEAD_W'(1);  // control header 2'b01

  logic [7:0]        bip3;
  logic [DATA_W-1:0] am_blk;

`ifdef PCS_AM_BIP_EN
  logic [7:0] bip_q;
  logic [7:0] par;

  // Column parity of one block: byte-wise XOR fold, header bits land on 3/4.
  always_comb begin
    par = '0;
    for (int b = 0; b < DATA_W/8; b++) par = par ^ src_data[8*b +: 8];
    par[3] = par[3] ^ src_head[0];
    par[4] = par[4] ^ src_head[1];
  end

  // A marker's payload folds to 0x00 (each byte meets its complement), so
  // the only parity it contributes is its header bit 0 -> constant 0x08.
  always_ff @(posedge clk) begin
    if (reset)     bip_q <= '0;
    else if (mark) bip_q <= 8'h08;
    else           bip_q <= bip_q ^ par;
  end

  assign bip3 = bip_q;
`else
  assign bip3 = 8'h00;
`endif

  // Bytes 0..7 = M0, M1, M2, BIP3, ~M0, ~M1, ~M2, ~BIP3
  assign am_blk = {~bip3, ~AM[23:16], ~AM[15:8], ~AM[7:0],
                    bip3,  AM[23:16],  AM[15:8],  AM[7:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      blk_head <= '0;
      blk_data <= '0;
    end else if (mark) begin
      blk_head <= AM_HEAD;
      blk_data <= am_blk;
    end else begin
      blk_head <= src_head;
      blk_data <= src_data;
    end
  end
endmodule

module pcs_am_insert #(
  parameter int                   LANE_N  = 4,
  parameter int                   DATA_W  = 64,
  parameter int                   HEAD_W  = 2,
  parameter int                   GAP_N   = 16383,
  parameter logic [LANE_N*24-1:0] AM_LANE = 96'h3D79A2_9B65C5_E6C4F0_477690
)(
  input  logic                     clk,
  input  logic                     reset,
  input  logic [LANE_N*HEAD_W-1:0] head_i,
  input  logic [LANE_N*DATA_W-1:0] data_i,
  output logic                     ready_o,
  output logic [LANE_N*HEAD_W-1:0] head_o,
  output logic [LANE_N*DATA_W-1:0] data_o,
  output logic                     am_v_o
);
  localparam int            CW      = $clog2(GAP_N + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(GAP_N);

  logic [CW-1:0] cnt_q;
  logic          mark;

  // Count 0 is the marker slot; the counter resets to it, so the first cycle
  // out of reset always emits a marker.
  assign mark    = (cnt_q == '0);
  assign ready_o = ~mark;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      am_v_o <= 1'b0;
    end else begin
      cnt_q  <= (cnt_q == CNT_MAX) ? '0 : cnt_q + CW'(1);
      am_v_o <= mark;
    end
  end

  for (genvar l = 0; l < LANE_N; l++) begin : g_lane
    pcs_am_lane #(
      .DATA_W (DATA_W),
      .HEAD_W (HEAD_W),
      .AM     (AM_LANE[24*l +: 24])
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .mark     (mark),
      .src_head (head_i[HEAD_W*l +: HEAD_W]),
      .src_data (data_i[DATA_W*l +: DATA_W]),
      .blk_head (head_o[HEAD_W*l +: HEAD_W]),
      .blk_data (data_o[DATA_W*l +: DATA_W])
    );
  end
endmodule
